wb_arbiter: RTL and testbench
=============================

// Module: wb_arbiter
// PURPOSE
//   Writeback stage directly upstream of the register file. Accepts results from
//   two producers: the single-cycle ALU (ex_*) and the multi-cycle unit (mu_*:
//   multiply/load). Arbitrates between them with an anti-starvation counter and
//   registers the winner onto the RF write port (rf_we/rf_rd/rf_wdata). It also
//   presents the in-flight write as a forwarding source for decode.
// PARAMETERS
//   XLEN       32  data width of results and rf_wdata
//   STARVE_MAX 3   consecutive ex losses before ex is granted priority (>=1)
//   CNT_W      2   width of starvation counter; must hold STARVE_MAX
// PORTS
//   clk        in   1     rising-edge clock
//   rst_n      in   1     asynchronous active-low reset
//   ex_valid   in   1     ALU result valid
//   ex_ready   out  1     ALU result accepted this cycle (ex_valid & ex_ready)
//   ex_rd      in   5     ALU destination register
//   ex_data    in   XLEN  ALU result
//   mu_valid   in   1     multi-cycle unit result valid
//   mu_ready   out  1     multi-cycle result accepted this cycle
//   mu_rd      in   5     multi-cycle destination register
//   mu_data    in   XLEN  multi-cycle result
//   rf_we      out  1     register-file write enable
//   rf_rd      out  5     register-file write address
//   rf_wdata   out  XLEN  register-file write data
//   fwd_valid  out  1     forwarding entry valid (equals rf_we)
//   fwd_rd     out  5     forwarding register index (equals rf_rd)
//   fwd_data   out  XLEN  forwarding data (equals rf_wdata)
//   starve_cnt out  CNT_W current starvation count (debug/verification)
// BEHAVIOUR
//   - Reset (rst_n=0, async): rf_we=0, rf_rd=0, rf_wdata=0, fwd_*=0, starve_cnt=0.
//     Any result presented during reset is dropped; ex_ready=mu_ready=0 while rst_n=0.
//   - Ready is combinational from the valids and starve_cnt; there is no stall input
//     because the RF accepts one write every cycle.
//   - Grant rule in each cycle:
//       * only one valid: that source is granted.
//       * both valid, starve_cnt<STARVE_MAX: mu is granted; ex_ready=0.
//       * both valid, starve_cnt==STARVE_MAX: ex is granted; mu_ready=0.
//       * neither valid: no grant; ex_ready=mu_ready=0.
//   - starve_cnt update at posedge:
//       * +1 when ex_valid & ~ex_ready. It saturates at STARVE_MAX.
//       * cleared to 0 when ex is granted.
//       * unchanged otherwise.
//   - Latency: the grant in cycle N appears on rf_*/fwd_* in cycle N+1 (one register).
//   - Output register at posedge:
//       * rf_rd and rf_wdata load the granted rd/data.
//       * rf_we = grant & (rd!=0).
//       * With no grant, rf_we=0 and rf_rd/rf_wdata hold their previous values.
//   - rd==0: the result is accepted (ready=1, handshake completes) but never written.
//     rf_we=0 and fwd_valid=0 for it.
//   - Producers must hold valid/rd/data stable until accepted. The block does not
//     buffer beyond the output register.
//   - fwd_* is wired directly from rf_*. Decode compares fwd_rd against its sources
//     to cover the cycle in which the RF write is not yet visible.
//   - Reset mid-operation clears the output register immediately (async). The
//     pending write is lost by design.
// TESTING
//   1 Reset: assert rst_n=0 mid-stream with rf_we=1.
//     -> rf_we, rf_rd, rf_wdata and starve_cnt are 0 without waiting for a clock edge.
//   2 Single ex: ex_valid=1, ex_rd=5, ex_data=0xDEADBEEF at cycle N.
//     -> ex_ready=1 in N; rf_we=1, rf_rd=5, rf_wdata=0xDEADBEEF in N+1; fwd_* identical.
//   3 x0 discard: mu_valid=1, mu_rd=0, mu_data=0x1234.
//     -> mu_ready=1; next cycle rf_we=0 and fwd_valid=0.
//   4 Contention: both valid continuously (ex_rd=1, mu_rd=2), STARVE_MAX=3.
//     -> mu granted 3 cycles (starve_cnt 1,2,3), then ex granted, starve_cnt=0.
//     -> The rf_rd sequence is 2,2,2,1,2,2,2,1...
//   5 Back-to-back: ex in cycle N and mu in cycle N+1 to the same rd=7 (0xA, then 0xB).
//     -> rf_wdata is 0xA in N+1 and 0xB in N+2; rf_we=1 in both cycles.
//   6 Idle: no valids for 4 cycles after a write.
//     -> rf_we=0; rf_rd/rf_wdata hold; starve_cnt unchanged.

Source files
------------

// File: rtl/wb_arbiter.sv
// Writeback arbiter: grants the ALU or the multi-cycle unit each cycle and registers the winner
// onto the register-file write port, which doubles as the decode forwarding source.
module wb_arbiter #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned STARVE_MAX = 3,
    parameter int unsigned CNT_W      = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ex_valid,
    output logic             ex_ready,
    input  logic [4:0]       ex_rd,
    input  logic [XLEN-1:0]  ex_data,
    input  logic             mu_valid,
    output logic             mu_ready,
    input  logic [4:0]       mu_rd,
    input  logic [XLEN-1:0]  mu_data,
    output logic             rf_we,
    output logic [4:0]       rf_rd,
    output logic [XLEN-1:0]  rf_wdata,
    output logic             fwd_valid,
    output logic [4:0]       fwd_rd,
    output logic [XLEN-1:0]  fwd_data,
    output logic [CNT_W-1:0] starve_cnt
);

    localparam logic [CNT_W-1:0] StarveMax = CNT_W'(STARVE_MAX);

    logic             ex_gnt, mu_gnt;
    logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
    logic             we_q, we_d;
    logic [4:0]       rd_q, rd_d;
    logic [XLEN-1:0]  data_q, data_d;

    // mu wins contention until ex has lost STARVE_MAX times in a row
    always_comb begin
        ex_gnt = ex_valid & (~mu_valid | (starve_cnt_q == StarveMax));
        mu_gnt = mu_valid & ~ex_gnt;
    end

    assign ex_ready = ex_gnt & rst_n;
    assign mu_ready = mu_gnt & rst_n;

    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (ex_gnt) begin
            starve_cnt_d = '0;
        end else if (ex_valid && (starve_cnt_q != StarveMax)) begin
            starve_cnt_d = starve_cnt_q + CNT_W'(1);
        end
    end

    // Writes to x0 complete the handshake but never raise the write enable
    always_comb begin
        we_d   = 1'b0;
        rd_d   = rd_q;
        data_d = data_q;
        if (ex_gnt) begin
            we_d   = |ex_rd;
            rd_d   = ex_rd;
            data_d = ex_data;
        end else if (mu_gnt) begin
            we_d   = |mu_rd;
            rd_d   = mu_rd;
            data_d = mu_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt_q <= '0;
            we_q         <= 1'b0;
            rd_q         <= '0;
            data_q       <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            we_q         <= we_d;
            rd_q         <= rd_d;
            data_q       <= data_d;
        end
    end

    assign rf_we      = we_q;
    assign rf_rd      = rd_q;
    assign rf_wdata   = data_q;
    assign fwd_valid  = we_q;
    assign fwd_rd     = rd_q;
    assign fwd_data   = data_q;
    assign starve_cnt = starve_cnt_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed scenarios plus a randomized run checked against a
// cycle-level model of the grant and starvation rules.
module tb_wb_arbiter;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned STARVE_MAX = 3;
    localparam int unsigned CNT_W      = 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             ex_valid = 1'b0, mu_valid = 1'b0;
    logic             ex_ready, mu_ready;
    logic [4:0]       ex_rd = '0, mu_rd = '0;
    logic [XLEN-1:0]  ex_data = '0, mu_data = '0;
    logic             rf_we, fwd_valid;
    logic [4:0]       rf_rd, fwd_rd;
    logic [XLEN-1:0]  rf_wdata, fwd_data;
    logic [CNT_W-1:0] starve_cnt;

    int n_pass = 0;
    int n_total = 0;

    // Model state
    int unsigned     m_cnt;
    logic            m_we;
    logic [4:0]      m_rd;
    logic [XLEN-1:0] m_data;
    logic            m_exg, m_mug;

    wb_arbiter #(.XLEN(XLEN), .STARVE_MAX(STARVE_MAX), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_rd(ex_rd), .ex_data(ex_data),
        .mu_valid(mu_valid), .mu_ready(mu_ready), .mu_rd(mu_rd), .mu_data(mu_data),
        .rf_we(rf_we), .rf_rd(rf_rd), .rf_wdata(rf_wdata),
        .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
        .starve_cnt(starve_cnt)
    );

    always #5 clk = ~clk;

    function automatic void model_reset();
        m_cnt = 0; m_we = 1'b0; m_rd = '0; m_data = '0;
    endfunction

    function automatic void model_grant();
        m_exg = 1'b0;
        m_mug = 1'b0;
        if (ex_valid && !mu_valid) m_exg = 1'b1;
        else if (!ex_valid && mu_valid) m_mug = 1'b1;
        else if (ex_valid && mu_valid) begin
            if (m_cnt < STARVE_MAX) m_mug = 1'b1;
            else m_exg = 1'b1;
        end
    endfunction

    function automatic void model_commit();
        model_grant();
        if (m_exg) m_cnt = 0;
        else if (ex_valid) m_cnt = (m_cnt + 1 > STARVE_MAX) ? STARVE_MAX : m_cnt + 1;
        if (m_exg) begin
            m_we = (ex_rd != 0); m_rd = ex_rd; m_data = ex_data;
        end else if (m_mug) begin
            m_we = (mu_rd != 0); m_rd = mu_rd; m_data = mu_data;
        end else begin
            m_we = 1'b0;
        end
    endfunction

    task automatic drive(input logic ev, input logic [4:0] erd, input logic [XLEN-1:0] ed,
                         input logic mv, input logic [4:0] mrd, input logic [XLEN-1:0] md);
        @(negedge clk);
        ex_valid = ev; ex_rd = erd; ex_data = ed;
        mu_valid = mv; mu_rd = mrd; mu_data = md;
        #1;
        model_grant();
    endtask

    task automatic tick();
        @(posedge clk);
        model_commit();
        #1;
    endtask

    task automatic test_reset();
        ex_valid = 1'b1; ex_rd = 5'd3; ex_data = 32'h1111;
        mu_valid = 1'b1; mu_rd = 5'd4; mu_data = 32'h2222;
        model_reset();
        #12;
        n_total++;
        if ({rf_we, rf_rd, rf_wdata, starve_cnt} !== '0)
            $display("FAIL reset_outputs: got we=%b rd=%0d data=%h cnt=%0d want all 0",
                     rf_we, rf_rd, rf_wdata, starve_cnt);
        else n_pass++;
        n_total++;
        if ({ex_ready, mu_ready} !== 2'b00)
            $display("FAIL reset_ready: got %b%b want 00", ex_ready, mu_ready);
        else n_pass++;
        @(negedge clk);
        ex_valid = 1'b0; mu_valid = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic test_single_ex();
        drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0);
        n_total++;
        if ({ex_ready, mu_ready} !== 2'b10)
            $display("FAIL single_ex_ready: got %b%b want 10", ex_ready, mu_ready);
        else n_pass++;
        tick();
        n_total++;
        if ({rf_we, rf_rd, rf_wdata} !== {1'b1, 5'd5, 32'hDEADBEEF})
            $display("FAIL single_ex_rf: got we=%b rd=%0d data=%h want 1 5 deadbeef",
                     rf_we, rf_rd, rf_wdata);
        else n_pass++;
        n_total++;
        if ({fwd_valid, fwd_rd, fwd_data} !== {1'b1, 5'd5, 32'hDEADBEEF})
            $display("FAIL single_ex_fwd: got v=%b rd=%0d data=%h want 1 5 deadbeef",
                     fwd_valid, fwd_rd, fwd_data);
        else n_pass++;
    endtask

    task automatic test_x0_discard();
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'h1234);
        n_total++;
        if ({ex_ready, mu_ready} !== 2'b01)
            $display("FAIL x0_ready: got %b%b want 01", ex_ready, mu_ready);
        else n_pass++;
        tick();
        n_total++;
        if ({rf_we, fwd_valid} !== 2'b00)
            $display("FAIL x0_we: got we=%b fwd_valid=%b want 0 0", rf_we, fwd_valid);
        else n_pass++;
    endtask

    task automatic test_contention();
        logic [4:0] exp_rd [8];
        int         exp_cnt [8];
        exp_rd  = '{5'd2, 5'd2, 5'd2, 5'd1, 5'd2, 5'd2, 5'd2, 5'd1};
        exp_cnt = '{1, 2, 3, 0, 1, 2, 3, 0};
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 5'd1, 32'hE0 + i, 1'b1, 5'd2, 32'hA0 + i);
            n_total++;
            if ({ex_ready, mu_ready} !== ((i % 4 == 3) ? 2'b10 : 2'b01))
                $display("FAIL contention_ready[%0d]: got %b%b", i, ex_ready, mu_ready);
            else n_pass++;
            tick();
            n_total++;
            if (rf_rd !== exp_rd[i] || int'(starve_cnt) != exp_cnt[i])
                $display("FAIL contention[%0d]: got rd=%0d cnt=%0d want rd=%0d cnt=%0d",
                         i, rf_rd, starve_cnt, exp_rd[i], exp_cnt[i]);
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        drive(1'b1, 5'd7, 32'hA, 1'b0, 5'd0, 32'h0);
        tick();
        n_total++;
        if ({rf_we, rf_rd, rf_wdata} !== {1'b1, 5'd7, 32'hA})
            $display("FAIL b2b_first: got we=%b rd=%0d data=%h want 1 7 a",
                     rf_we, rf_rd, rf_wdata);
        else n_pass++;
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'hB);
        tick();
        n_total++;
        if ({rf_we, rf_rd, rf_wdata} !== {1'b1, 5'd7, 32'hB})
            $display("FAIL b2b_second: got we=%b rd=%0d data=%h want 1 7 b",
                     rf_we, rf_rd, rf_wdata);
        else n_pass++;
    endtask

    task automatic test_idle();
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
            tick();
            n_total++;
            if ({rf_we, rf_rd, rf_wdata, starve_cnt} !== {1'b0, 5'd7, 32'hB, CNT_W'(0)})
                $display("FAIL idle[%0d]: got we=%b rd=%0d data=%h cnt=%0d want 0 7 b 0",
                         i, rf_we, rf_rd, rf_wdata, starve_cnt);
            else n_pass++;
        end
    endtask

    task automatic test_async_reset();
        drive(1'b1, 5'd9, 32'h55, 1'b1, 5'd10, 32'h66);
        tick();
        n_total++;
        if ({rf_we, rf_rd, starve_cnt} !== {1'b1, 5'd10, CNT_W'(1)})
            $display("FAIL async_pre: got we=%b rd=%0d cnt=%0d want 1 10 1",
                     rf_we, rf_rd, starve_cnt);
        else n_pass++;
        #1;
        rst_n = 1'b0;
        model_reset();
        #1;
        n_total++;
        if ({rf_we, rf_rd, rf_wdata, fwd_valid, starve_cnt} !== '0)
            $display("FAIL async_reset: got we=%b rd=%0d data=%h fv=%b cnt=%0d want all 0",
                     rf_we, rf_rd, rf_wdata, fwd_valid, starve_cnt);
        else n_pass++;
        n_total++;
        if ({ex_ready, mu_ready} !== 2'b00)
            $display("FAIL async_ready: got %b%b want 00", ex_ready, mu_ready);
        else n_pass++;
        @(negedge clk);
        ex_valid = 1'b0; mu_valid = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic test_random();
        logic            p_ev = 1'b0, p_mv = 1'b0;
        logic [4:0]      p_erd = '0, p_mrd = '0;
        logic [XLEN-1:0] p_ed = '0, p_md = '0;
        logic            acc_ex, acc_mu;
        int              errs = 0;
        for (int i = 0; i < 300; i++) begin
            if (!p_ev) begin
                p_ev = ($urandom_range(0, 3) != 0);
                p_erd = 5'($urandom_range(0, 31));
                p_ed = $urandom;
            end
            if (!p_mv) begin
                p_mv = ($urandom_range(0, 2) != 0);
                p_mrd = 5'($urandom_range(0, 31));
                p_md = $urandom;
            end
            drive(p_ev, p_erd, p_ed, p_mv, p_mrd, p_md);
            acc_ex = m_exg;
            acc_mu = m_mug;
            n_total++;
            if ({ex_ready, mu_ready} !== {m_exg, m_mug}) begin
                errs++;
                if (errs < 10) $display("FAIL rand_ready[%0d]: got %b%b want %b%b",
                                        i, ex_ready, mu_ready, m_exg, m_mug);
            end else n_pass++;
            tick();
            n_total++;
            if ({rf_we, rf_rd, rf_wdata, fwd_valid, fwd_rd, fwd_data, starve_cnt} !==
                {m_we, m_rd, m_data, m_we, m_rd, m_data, CNT_W'(m_cnt)}) begin
                errs++;
                if (errs < 10)
                    $display("FAIL rand_out[%0d]: got we=%b rd=%0d data=%h cnt=%0d want %b %0d %h %0d",
                             i, rf_we, rf_rd, rf_wdata, starve_cnt, m_we, m_rd, m_data, m_cnt);
            end else n_pass++;
            if (acc_ex) p_ev = 1'b0;
            if (acc_mu) p_mv = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_single_ex();
        test_x0_discard();
        test_contention();
        test_back_to_back();
        test_idle();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
